// File: rtl/arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package arb_pkg;

  // Which requester is owed read data in the following cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  // Width of the dbg starvation counter; limits STARVE_LIMIT to 1..255.
  localparam int STARVE_CNT_W = 8;

  // Owner to record for a granted access: only reads expect a response.
  function automatic owner_t read_owner(input logic cpu_gnt, input logic cpu_we,
                                        input logic dbg_gnt, input logic dbg_we);
    owner_t o;
    o = OWN_NONE;
    if (cpu_gnt && !cpu_we) o = OWN_CPU;
    else if (dbg_gnt && !dbg_we) o = OWN_DBG;
    return o;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory.
// cpu has fixed priority; a saturating starvation counter forces a dbg
// grant after STARVE_LIMIT consecutive denied dbg cycles. Read data comes
// back one cycle after the grant and is steered to the port that issued it.
module dmem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  // memory-access stage
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_be,
  output logic                    cpu_gnt,
  output logic                    cpu_rvalid,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  // debug / DMA port
  input  logic                    dbg_req,
  input  logic                    dbg_we,
  input  logic [ADDR_WIDTH-1:0]   dbg_addr,
  input  logic [DATA_WIDTH-1:0]   dbg_wdata,
  input  logic [DATA_WIDTH/8-1:0] dbg_be,
  output logic                    dbg_gnt,
  output logic                    dbg_rvalid,
  output logic [DATA_WIDTH-1:0]   dbg_rdata,
  // memory control bus
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt_reg;
  logic [STARVE_CNT_W-1:0] starve_cnt_next;
  owner_t                  rd_owner_reg;
  owner_t                  rd_owner_next;
  logic                    force_dbg;

  assign force_dbg = dbg_req && (starve_cnt_reg == LIMIT);

  // Grant selection: forced dbg, else cpu, else dbg; nothing while in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!reset) begin
      if (force_dbg)    dbg_gnt = 1'b1;
      else if (cpu_req) cpu_gnt = 1'b1;
      else if (dbg_req) dbg_gnt = 1'b1;
    end
  end

  // Memory bus mirrors the granted port; all fields are zero when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_be    = cpu_be;
    end else if (dbg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_be    = dbg_be;
    end
  end

  // Next-state for the starvation counter and the read-return owner.
  // A withdrawn dbg request clears the counter, so it never carries over.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!dbg_req || dbg_gnt)
      starve_cnt_next = '0;
    else if (starve_cnt_reg < LIMIT)
      starve_cnt_next = starve_cnt_reg + STARVE_CNT_W'(1);
    rd_owner_next = read_owner(cpu_gnt, cpu_we, dbg_gnt, dbg_we);
  end

  // State registers; reset drops any read still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_reg <= '0;
      rd_owner_reg   <= OWN_NONE;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      rd_owner_reg   <= rd_owner_next;
    end
  end

  // Read return: only the owning port sees valid data, the other reads 0.
  always_comb begin
    cpu_rvalid = (rd_owner_reg == OWN_CPU);
    dbg_rvalid = (rd_owner_reg == OWN_DBG);
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a driver issues per-cycle vectors with
// hand-computed grants and pushes expected read responses; a monitor pops
// and compares whenever read data is due.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [3:0]  cpu_be, dbg_be;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic        is_dbg;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_be(dbg_be), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memory model: byte-enabled writes, registered reads.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: read data is due exactly at the cycle recorded by the driver.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("[TB] cycle %0d rsp %s data=0x%08h", cyc, e.is_dbg ? "dbg" : "cpu", e.data);
      if (e.is_dbg) begin
        check("dbg_rvalid", {31'b0, dbg_rvalid}, 32'd1);
        check("dbg_rdata", dbg_rdata, e.data);
        check("cpu_rvalid_idle", {31'b0, cpu_rvalid}, 32'd0);
      end else begin
        check("cpu_rvalid", {31'b0, cpu_rvalid}, 32'd1);
        check("cpu_rdata", cpu_rdata, e.data);
        check("dbg_rvalid_idle", {31'b0, dbg_rvalid}, 32'd0);
      end
    end else if (cpu_rvalid || dbg_rvalid) begin
      tests++;
      fails++;
      $display("FAIL spurious_rvalid: cpu_rvalid=%0b dbg_rvalid=%0b, want 0 (cycle %0d)",
               cpu_rvalid, dbg_rvalid, cyc);
    end
  end

  // One bus cycle: drive, check grant/bus mid-cycle, queue expected read data.
  task automatic step(input string name,
                      input logic creq, input logic cwe, input logic [31:0] caddr,
                      input logic dreq, input logic dwe, input logic [31:0] daddr,
                      input logic [31:0] dwdata, input logic [3:0] dbe,
                      input logic ecg, input logic edg, input logic [31:0] erd);
    exp_t e;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = 32'hC0DE_0000; cpu_be = 4'hF;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwdata; dbg_be = dbe;
    @(negedge clk);
    $display("[TB] cycle %0d %s cpu_gnt=%0b dbg_gnt=%0b mem_en=%0b addr=0x%08h",
             cyc, name, cpu_gnt, dbg_gnt, mem_en, mem_addr);
    check({name, ".cpu_gnt"}, {31'b0, cpu_gnt}, {31'b0, ecg});
    check({name, ".dbg_gnt"}, {31'b0, dbg_gnt}, {31'b0, edg});
    check({name, ".mem_en"}, {31'b0, mem_en}, {31'b0, ecg | edg});
    if (ecg) begin
      check({name, ".mem_addr"}, mem_addr, caddr);
      check({name, ".mem_we"}, {31'b0, mem_we}, {31'b0, cwe});
    end else if (edg) begin
      check({name, ".mem_addr"}, mem_addr, daddr);
      check({name, ".mem_we"}, {31'b0, mem_we}, {31'b0, dwe});
      if (dwe) begin
        check({name, ".mem_wdata"}, mem_wdata, dwdata);
        check({name, ".mem_be"}, {28'b0, mem_be}, {28'b0, dbe});
      end
    end else begin
      check({name, ".mem_we_idle"}, {31'b0, mem_we}, 32'd0);
      check({name, ".mem_addr_idle"}, mem_addr, 32'd0);
    end
    if ((ecg && !cwe) || (edg && !dwe)) begin
      e.is_dbg = edg;
      e.data   = erd;
      e.due    = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string name);
    step(name, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'h1111_1111;
    mem[1]  = 32'h2222_2222;
    mem[2]  = 32'h3333_3333;
    mem[16] = 32'hAABB_CCDD;
    mem[64] = 32'hDEAD_BEEF;
    mem_rdata = 32'h0;

    // Reset held with both requesters active: no grant, no bus activity.
    reset = 1'b1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100; cpu_wdata = 0; cpu_be = 4'hF;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h0;   dbg_wdata = 0; dbg_be = 4'hF;
    repeat (2) @(negedge clk);
    check("rst.cpu_gnt", {31'b0, cpu_gnt}, 32'd0);
    check("rst.dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    check("rst.mem_en", {31'b0, mem_en}, 32'd0);
    check("rst.cpu_rvalid", {31'b0, cpu_rvalid}, 32'd0);
    check("rst.dbg_rdata", dbg_rdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Contention from release: cpu x4, forced dbg, repeated twice.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++)
        step("contend_cpu", 1, 0, 32'h100, 1, 0, 32'h0, 32'h0, 4'hF, 1, 0, 32'hDEAD_BEEF);
      step("contend_dbg", 1, 0, 32'h100, 1, 0, 32'h0, 32'h0, 4'hF, 0, 1, 32'h1111_1111);
    end
    idle("idle0");

    // Partial dbg write, then cpu read-back of the merged word.
    step("dbg_write", 0, 0, 32'h0, 1, 1, 32'h40, 32'h1234_5678, 4'b0011, 0, 1, 32'h0);
    step("cpu_rd_40", 1, 0, 32'h40, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'hAABB_5678);

    // Back-to-back cpu reads.
    step("b2b_0", 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h1111_1111);
    step("b2b_4", 1, 0, 32'h4, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h2222_2222);
    step("b2b_8", 1, 0, 32'h8, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h3333_3333);
    idle("idle1");

    // dbg withdrawn after two denied cycles: counter must restart from zero.
    step("wd_a", 1, 0, 32'h0, 1, 0, 32'h4, 32'h0, 4'hF, 1, 0, 32'h1111_1111);
    step("wd_b", 1, 0, 32'h0, 1, 0, 32'h4, 32'h0, 4'hF, 1, 0, 32'h1111_1111);
    step("wd_drop", 1, 0, 32'h0, 0, 0, 32'h4, 32'h0, 4'hF, 1, 0, 32'h1111_1111);
    for (int k = 0; k < 4; k++)
      step("wd_cpu", 1, 0, 32'h8, 1, 0, 32'h4, 32'h0, 4'hF, 1, 0, 32'h3333_3333);
    step("wd_dbg", 1, 0, 32'h8, 1, 0, 32'h4, 32'h0, 4'hF, 0, 1, 32'h2222_2222);
    idle("idle2");

    // Reset right after a granted dbg read: the response is dropped.
    step("rst_rd", 0, 0, 32'h0, 1, 0, 32'h4, 32'h0, 4'hF, 0, 1, 32'h2222_2222);
    void'(exp_q.pop_back());
    reset = 1'b1;
    dbg_req = 1'b0;
    @(negedge clk);
    check("rst_mid.dbg_rvalid", {31'b0, dbg_rvalid}, 32'd0);
    check("rst_mid.dbg_rdata", dbg_rdata, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle("post_rst0");
    idle("post_rst1");
    step("post_rst_rd", 1, 0, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'hDEAD_BEEF);
    idle("post_rst2");
    idle("post_rst3");

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL pending_rsp: %0d responses never seen, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
